// File: rtl/seg_display_driver_pkg.sv
// Shared constants for the calculator display stage: active-low 7-segment codes,
// the saturation limit for the shown magnitude and the conversion FSM states.
package seg_display_driver_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int unsigned MAX_MAG = 9999;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } conv_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
        logic [6:0] w_seg;
        case (i_nib)
            4'h0:    w_seg = SEG_0;
            4'h1:    w_seg = SEG_1;
            4'h2:    w_seg = SEG_2;
            4'h3:    w_seg = SEG_3;
            4'h4:    w_seg = SEG_4;
            4'h5:    w_seg = SEG_5;
            4'h6:    w_seg = SEG_6;
            4'h7:    w_seg = SEG_7;
            4'h8:    w_seg = SEG_8;
            4'h9:    w_seg = SEG_9;
            4'hA:    w_seg = 7'b0001000;
            4'hB:    w_seg = 7'b0000011;
            4'hC:    w_seg = 7'b1000110;
            4'hD:    w_seg = 7'b0100001;
            4'hE:    w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: a start pulse loads the binary value and clears the
// BCD scratch, then 16 add-3/shift steps run and done pulses for one cycle.
module seg_display_driver_bin2bcd_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [13:0] i_value,
    output logic [15:0] o_bcd,
    output logic        o_done
);

    logic [15:0] r_bcd;
    logic [15:0] r_bin;
    logic [4:0]  r_cnt;
    logic        r_active;
    logic        r_done;

    logic [15:0] w_adj;
    logic [31:0] w_shift;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd    <= '0;
            r_bin    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bcd    <= '0;
                r_bin    <= {2'b00, i_value};
                r_cnt    <= 5'd16;
                r_active <= 1'b1;
            end else if (r_active) begin
                r_bcd <= w_shift[31:16];
                r_bin <= w_shift[15:0];
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = r_done;

endmodule

// File: rtl/seg_display_driver.sv
// Display stage: captures a signed value, converts |value| to BCD in the background,
// and scans the four common-anode digits with minus sign, overflow dashes and blink.
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_value,
    input  logic        i_overflow,
    input  logic        i_edit_en,
    input  logic [1:0]  i_digit,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [3:0]  o_an,
    output logic        o_busy
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    conv_state_e r_state, w_state_next;
    logic        w_capture;
    logic        w_start;
    logic        w_done;
    logic [15:0] w_bcd;

    logic [15:0] r_last;
    logic [15:0] r_val_cap;
    logic [13:0] r_mag;
    logic        r_sign_cap;
    logic [15:0] r_shown_bcd;
    logic        r_shown_sign;

    logic [16:0] w_ext;
    logic [16:0] w_abs;
    logic [13:0] w_mag;
    logic        w_sign;

    logic [REF_W-1:0] r_refresh;
    logic [1:0]       r_idx;
    logic [BLK_W-1:0] r_blink;
    logic             r_phase;

    logic [6:0] r_seg, w_seg;
    logic       r_dp, w_dp;
    logic [3:0] r_an, w_an;
    logic [3:0] w_nib;

    // 17-bit magnitude so that -32768 does not wrap before saturation
    always_comb begin
        w_ext  = {i_value[15], i_value};
        w_abs  = i_value[15] ? (17'd0 - w_ext) : w_ext;
        w_mag  = (w_abs > 17'(MAX_MAG)) ? 14'(MAX_MAG) : w_abs[13:0];
        w_sign = i_value[15] && (w_mag != 14'd0);
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_value != r_last) begin
                    w_capture    = 1'b1;
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_start      = 1'b1;
                w_state_next = StShift;
            end
            StShift: begin
                if (w_done) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_last       <= '0;
            r_val_cap    <= '0;
            r_mag        <= '0;
            r_sign_cap   <= 1'b0;
            r_shown_bcd  <= '0;
            r_shown_sign <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_val_cap  <= i_value;
                r_mag      <= w_mag;
                r_sign_cap <= w_sign;
            end
            // Digits and sign change together so no partial result is ever shown
            if (r_state == StDone) begin
                r_shown_bcd  <= w_bcd;
                r_shown_sign <= r_sign_cap;
                r_last       <= r_val_cap;
            end
        end
    end

    seg_display_driver_bin2bcd_seq u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_value (r_mag),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_blink   <= '0;
            r_phase   <= 1'b0;
        end else begin
            if (r_refresh == REF_LAST) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + REF_W'(1);
            end
            if (r_blink == BLK_LAST) begin
                r_blink <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_blink <= r_blink + BLK_W'(1);
            end
        end
    end

    always_comb begin
        w_nib = r_shown_bcd[{r_idx, 2'b00} +: 4];
        w_seg = hex_to_seg(w_nib);
        if (i_overflow) begin
            w_seg = SEG_DASH;
        end else if (i_edit_en && (r_idx == i_digit) && r_phase) begin
            w_seg = SEG_BLANK;
        end
        w_dp = ~((r_idx == 2'd3) && r_shown_sign && !i_overflow);
        w_an = ~(4'b0001 << r_idx);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
        end
    end

    assign o_seg  = r_seg;
    assign o_dp   = r_dp;
    assign o_an   = r_an;
    assign o_busy = (r_state != StIdle);

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with REFRESH_DIV=4 and BLINK_DIV=16.
module tb_seg_display_driver;

    localparam logic [6:0] S0     = 7'h40;
    localparam logic [6:0] S1     = 7'h79;
    localparam logic [6:0] S2     = 7'h24;
    localparam logic [6:0] S3     = 7'h30;
    localparam logic [6:0] S4     = 7'h19;
    localparam logic [6:0] S5     = 7'h12;
    localparam logic [6:0] S6     = 7'h02;
    localparam logic [6:0] S9     = 7'h10;
    localparam logic [6:0] SDASH  = 7'h3F;
    localparam logic [6:0] SBLANK = 7'h7F;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        overflow;
    logic        edit_en;
    logic [1:0]  digit;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_display_driver #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_value    (value),
        .i_overflow (overflow),
        .i_edit_en  (edit_en),
        .i_digit    (digit),
        .o_seg      (seg),
        .o_dp       (dp),
        .o_an       (an),
        .o_busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next fresh appearance of an anode code, sampling at negedges
    task automatic wait_an(input logic [3:0] code, input string tag);
        int g;
        g = 0;
        while (an == code && g < 40) begin
            @(negedge clk);
            g++;
        end
        while (an != code && g < 80) begin
            @(negedge clk);
            g++;
        end
        if (an != code) check({tag, "_timeout"}, an, code);
    endtask

    task automatic digit_check(input logic [3:0] code, input logic [6:0] exp_seg,
                               input logic exp_dp, input string tag);
        wait_an(code, tag);
        check({tag, "_seg"}, seg, exp_seg);
        check({tag, "_dp"}, dp, exp_dp);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        for (int g = 0; g < 80; g++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0 || g >= 8) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nb;
        int   bad;
        int   saw1;
        logic [6:0] a;

        rst      = 1'b1;
        value    = 16'd0;
        overflow = 1'b0;
        edit_en  = 1'b0;
        digit    = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, SBLANK);
        check("rst_dp", dp, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        digit_check(4'b1110, S0, 1'b1, "zero_d0");
        check("zero_no_busy", busy, 1'b0);

        // 1234
        value = 16'd1234;
        measure_busy(nb);
        check("busy_1234", nb, 19);
        digit_check(4'b1110, S4, 1'b1, "v1234_d0");
        digit_check(4'b1101, S3, 1'b1, "v1234_d1");
        digit_check(4'b1011, S2, 1'b1, "v1234_d2");
        digit_check(4'b0111, S1, 1'b1, "v1234_d3");

        // -56 interrupted by reset mid-conversion; reset aborts and it restarts from 0
        value = 16'hFFC8;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_an", an, 4'b1111);
        check("midrst_seg", seg, SBLANK);
        check("midrst_dp", dp, 1'b1);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        measure_busy(nb);
        check("busy_m56", nb, 19);
        digit_check(4'b1110, S6, 1'b1, "m56_d0");
        digit_check(4'b1101, S5, 1'b1, "m56_d1");
        digit_check(4'b1011, S0, 1'b1, "m56_d2");
        digit_check(4'b0111, S0, 1'b0, "m56_d3");

        // Overflow overrides digits and sign
        overflow = 1'b1;
        digit_check(4'b1110, SDASH, 1'b1, "ovf_d0");
        digit_check(4'b1101, SDASH, 1'b1, "ovf_d1");
        digit_check(4'b1011, SDASH, 1'b1, "ovf_d2");
        digit_check(4'b0111, SDASH, 1'b1, "ovf_d3");
        overflow = 1'b0;
        digit_check(4'b0111, S0, 1'b0, "ovf_off_d3");

        // -32768 saturates to 9999
        value = 16'h8000;
        measure_busy(nb);
        check("busy_min", nb, 19);
        digit_check(4'b1110, S9, 1'b1, "min_d0");
        digit_check(4'b0111, S9, 1'b0, "min_d3");

        // 100 then 200 five clocks into the conversion
        value = 16'd100;
        repeat (5) @(posedge clk);
        #1 value = 16'd200;
        measure_busy(nb);
        check("busy_100_rest", nb, 15);  // 4 busy samples elapsed before the change
        bad  = 0;
        saw1 = 0;
        nb   = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (seg != S0 && seg != S1) bad++;
            if (an == 4'b1011 && seg == S1) saw1++;
        end
        check("v100_no_partial", bad, 0);
        check("v100_shown", (saw1 > 0), 1'b1);
        check("busy_200", nb, 19);
        @(negedge clk);
        check("busy_200_end", busy, 1'b0);
        digit_check(4'b1011, S2, 1'b1, "v200_d2");
        digit_check(4'b1101, S0, 1'b1, "v200_d1");

        // Blink on digit 2: reset aligns the scan and blink counters
        rst     = 1'b1;
        edit_en = 1'b1;
        digit   = 2'd2;
        @(negedge clk);
        rst = 1'b0;
        measure_busy(nb);
        check("busy_edit", nb, 19);
        wait_an(4'b1011, "blink_a");
        a = seg;
        check("blink_a", a, SBLANK);
        digit_check(4'b1101, S0, 1'b1, "steady_d1a");
        wait_an(4'b1011, "blink_b");
        check("blink_b", seg, S2);
        digit_check(4'b1101, S0, 1'b1, "steady_d1b");
        wait_an(4'b1011, "blink_c");
        check("blink_c", seg, SBLANK);
        edit_en = 1'b0;
        wait_an(4'b1011, "noblink_a");
        check("noblink_a", seg, S2);
        wait_an(4'b1011, "noblink_b");
        check("noblink_b", seg, S2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
